// File: rtl/hit_scheduler.sv
// hit_scheduler
//   Damage sequencer between the hazard/obstacle requesters and the HP bar.
//   Arbitrates level hit requests round-robin. Each accepted hit produces one
//   single-cycle player_hit pulse, then a frame-counted invulnerability
//   window, with accumulated damage tracked up to a death limit.
//
// Ports
//   pclk        in   pixel clock, the only clock
//   rst         in   asynchronous reset, active-low
//   game_on     in   game running level; low returns the block to IDLE
//   vsync_in    in   vertical sync; each rising edge is one frame tick
//   hit_req     in   [N_SRC] per-source level request, held until acked
//   hit_ack     out  [N_SRC] one-hot single-cycle acknowledge
//   player_hit  out  single-cycle damage pulse to the HP bar
//   dmg_count   out  [3] damage taken, 0..MAX_DMG
//   invuln      out  high during the invulnerability window
//   last_src    out  [3] index of the most recently damaging source
//   game_over   out  high while dead
module hit_scheduler #(
  parameter int N_SRC         = 4,
  parameter int MAX_DMG       = 5,
  parameter int IFRAME_FRAMES = 60
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             game_on,
  input  logic             vsync_in,
  input  logic [N_SRC-1:0] hit_req,
  output logic [N_SRC-1:0] hit_ack,
  output logic             player_hit,
  output logic [2:0]       dmg_count,
  output logic             invuln,
  output logic [2:0]       last_src,
  output logic             game_over
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

  localparam logic [2:0]       MAX_DMG_L = 3'(MAX_DMG);
  localparam logic [7:0]       IFRAME_L  = 8'(IFRAME_FRAMES);
  localparam logic [N_SRC-1:0] ONE_HOT0  = N_SRC'(1);

  state_t           state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             vsync_prev_q;
  logic [N_SRC-1:0] hit_ack_q, hit_ack_d;
  logic             player_hit_q, player_hit_d;
  logic [2:0]       dmg_count_q, dmg_count_d;
  logic             invuln_q, invuln_d;
  logic [2:0]       last_src_q, last_src_d;
  logic             game_over_q, game_over_d;

  logic             tick;
  logic             busy;
  logic [3:0]       rr_sel;
  logic [3:0]       low_sel;

  // Round-robin pick: {found, index}. Scanning offsets from high to low lets
  // the smallest offset from ptr overwrite the result and win.
  function automatic logic [3:0] rr_pick(input logic [N_SRC-1:0] req,
                                         input logic [2:0]       ptr);
    logic [3:0] r;
    int         j;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N_SRC;
      if (req[j]) r = {1'b1, 3'(j)};
    end
    return r;
  endfunction

  // Fixed-priority pick of the lowest set index: {found, index}.
  function automatic logic [3:0] low_pick(input logic [N_SRC-1:0] req);
    logic [3:0] r;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] d);
    return (d >= MAX_DMG_L) ? MAX_DMG_L : d + 3'd1;
  endfunction

  function automatic logic [2:0] next_ptr(input logic [2:0] w);
    return 3'((int'(w) + 1) % N_SRC);
  endfunction

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    hit_ack_d    = '0;
    player_hit_d = 1'b0;
    dmg_count_d  = dmg_count_q;
    last_src_d   = last_src_q;

    tick    = vsync_in & ~vsync_prev_q;
    // During an ack cycle the acked requester has not yet dropped its level,
    // so no new grant or absorption is made until the ack has gone away.
    busy    = |hit_ack_q;
    rr_sel  = rr_pick(hit_req, rr_ptr_q);
    low_sel = low_pick(hit_req);

    if (!game_on) begin
      state_d     = IDLE;
      rr_ptr_d    = '0;
      cnt_d       = '0;
      dmg_count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = ARMED;
          rr_ptr_d    = '0;
          cnt_d       = '0;
          dmg_count_d = '0;
        end
        ARMED: begin
          if (rr_sel[3] && !busy) begin
            hit_ack_d    = ONE_HOT0 << rr_sel[2:0];
            player_hit_d = 1'b1;
            dmg_count_d  = sat_inc(dmg_count_q);
            last_src_d   = rr_sel[2:0];
            rr_ptr_d     = next_ptr(rr_sel[2:0]);
            if (dmg_count_d == MAX_DMG_L) begin
              state_d = DEAD;
              cnt_d   = '0;
            end else if (IFRAME_FRAMES != 0) begin
              state_d = INVULN;
              cnt_d   = IFRAME_L;
            end
          end
        end
        INVULN: begin
          if (tick) begin
            if (cnt_q <= 8'd1) begin
              state_d = ARMED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
          if (low_sel[3] && !busy) hit_ack_d = ONE_HOT0 << low_sel[2:0];
        end
        DEAD: begin
          if (low_sel[3] && !busy) hit_ack_d = ONE_HOT0 << low_sel[2:0];
        end
        default: state_d = IDLE;
      endcase
    end

    invuln_d    = (state_d == INVULN);
    game_over_d = (state_d == DEAD);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      vsync_prev_q <= 1'b0;
      hit_ack_q    <= '0;
      player_hit_q <= 1'b0;
      dmg_count_q  <= '0;
      invuln_q     <= 1'b0;
      last_src_q   <= '0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      vsync_prev_q <= vsync_in;
      hit_ack_q    <= hit_ack_d;
      player_hit_q <= player_hit_d;
      dmg_count_q  <= dmg_count_d;
      invuln_q     <= invuln_d;
      last_src_q   <= last_src_d;
      game_over_q  <= game_over_d;
    end
  end

  assign hit_ack    = hit_ack_q;
  assign player_hit = player_hit_q;
  assign dmg_count  = dmg_count_q;
  assign invuln     = invuln_q;
  assign last_src   = last_src_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_hit_scheduler.sv
module tb_hit_scheduler;

  logic       pclk = 1'b0;
  logic       rst;
  logic       game_on;
  logic       vsync_in;
  logic [3:0] req0, req1;

  logic [3:0] ack0, ack1;
  logic       ph0, ph1;
  logic [2:0] dmg0, dmg1;
  logic       inv0, inv1;
  logic [2:0] last0, last1;
  logic       go0, go1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_pulse1 = -1;

  // {ack[3:0], player_hit, dmg[2:0], last_src[2:0], invuln, game_over}
  logic [12:0] q0[$];
  logic [12:0] q1[$];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  hit_scheduler #(.N_SRC(4), .MAX_DMG(5), .IFRAME_FRAMES(60)) u0 (
    .pclk(pclk), .rst(rst), .game_on(game_on), .vsync_in(vsync_in),
    .hit_req(req0), .hit_ack(ack0), .player_hit(ph0), .dmg_count(dmg0),
    .invuln(inv0), .last_src(last0), .game_over(go0)
  );

  hit_scheduler #(.N_SRC(4), .MAX_DMG(5), .IFRAME_FRAMES(0)) u1 (
    .pclk(pclk), .rst(rst), .game_on(game_on), .vsync_in(vsync_in),
    .hit_req(req1), .hit_ack(ack1), .player_hit(ph1), .dmg_count(dmg1),
    .invuln(inv1), .last_src(last1), .game_over(go1)
  );

  function automatic logic [12:0] mk(input logic [3:0] a, input logic p,
                                     input logic [2:0] d, input logic [2:0] l,
                                     input logic i, input logic g);
    return {a, p, d, l, i, g};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requesters hold their level until they see their ack, then drop it.
  always @(negedge pclk) begin
    if (|ack0) req0 = req0 & ~ack0;
    if (|ack1) req1 = req1 & ~ack1;
  end

  // Scoreboard monitor for the windowed instance.
  always @(negedge pclk) begin
    logic [12:0] act, exp;
    if (rst && (|ack0 || ph0)) begin
      act = {ack0, ph0, dmg0, last0, inv0, go0};
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL u0_unexpected: got ack=%b ph=%b dmg=%0d last=%0d inv=%b go=%b expected no output",
                 ack0, ph0, dmg0, last0, inv0, go0);
      end else begin
        exp = q0.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL u0_resp: got ack=%b ph=%b dmg=%0d last=%0d inv=%b go=%b expected ack=%b ph=%b dmg=%0d last=%0d inv=%b go=%b",
                   act[12:9], act[8], act[7:5], act[4:2], act[1], act[0],
                   exp[12:9], exp[8], exp[7:5], exp[4:2], exp[1], exp[0]);
        end
      end
    end
  end

  // Scoreboard monitor for the zero-window instance, plus pulse spacing.
  always @(negedge pclk) begin
    logic [12:0] act, exp;
    if (rst && (|ack1 || ph1)) begin
      act = {ack1, ph1, dmg1, last1, inv1, go1};
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL u1_unexpected: got ack=%b ph=%b dmg=%0d expected no output", ack1, ph1, dmg1);
      end else begin
        exp = q1.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL u1_resp: got ack=%b ph=%b dmg=%0d last=%0d inv=%b go=%b expected ack=%b ph=%b dmg=%0d last=%0d inv=%b go=%b",
                   act[12:9], act[8], act[7:5], act[4:2], act[1], act[0],
                   exp[12:9], exp[8], exp[7:5], exp[4:2], exp[1], exp[0]);
        end
      end
      if (ph1) begin
        if (last_pulse1 >= 0) chk("u1_spacing", cyc - last_pulse1, 2);
        last_pulse1 = cyc;
      end
    end
  end

  task automatic wait_clr0(input logic [3:0] mask);
    for (int i = 0; i < 30 && (req0 & mask) != 0; i++) @(negedge pclk);
    chk("u0_ack_timeout", 32'(req0 & mask), 0);
  endtask

  task automatic hit0(input int src, input logic [12:0] exp);
    q0.push_back(exp);
    req0[src] = 1'b1;
    wait_clr0(4'b0001 << src);
    @(negedge pclk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk) vsync_in = 1'b1;
      @(negedge pclk);
      @(negedge pclk) vsync_in = 1'b0;
      @(negedge pclk);
    end
  endtask

  task automatic restart_game();
    @(negedge pclk) game_on = 1'b0;
    @(negedge pclk) game_on = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_ack"},  32'(ack0), 0);
    chk({tag, "_ph"},   32'(ph0), 0);
    chk({tag, "_dmg"},  32'(dmg0), 0);
    chk({tag, "_inv"},  32'(inv0), 0);
    chk({tag, "_last"}, 32'(last0), 0);
    chk({tag, "_go"},   32'(go0), 0);
  endtask

  initial begin
    rst = 1'b0; game_on = 1'b0; vsync_in = 1'b0; req0 = '0; req1 = '0;
    repeat (3) @(negedge pclk);
    chk_zero0("reset");

    // First hit from source 2, then the full window.
    rst = 1'b1; game_on = 1'b1;
    repeat (2) @(negedge pclk);
    hit0(2, mk(4'b0100, 1, 3'd1, 3'd2, 1, 0));
    chk("a_dmg", 32'(dmg0), 1);
    ticks(60);
    chk("a_inv_end", 32'(inv0), 0);

    // Simultaneous requests with rr_ptr back at 0: source 1 wins, 3 absorbed.
    restart_game();
    q0.push_back(mk(4'b0010, 1, 3'd1, 3'd1, 1, 0));
    q0.push_back(mk(4'b1000, 0, 3'd1, 3'd1, 1, 0));
    req0 = 4'b1010;
    wait_clr0(4'b1010);
    ticks(59);
    chk("b_inv_59", 32'(inv0), 1);
    ticks(1);
    chk("b_inv_60", 32'(inv0), 0);
    chk("b_dmg", 32'(dmg0), 1);

    hit0(0, mk(4'b0001, 1, 3'd2, 3'd0, 1, 0));
    ticks(60);
    hit0(3, mk(4'b1000, 1, 3'd3, 3'd3, 1, 0));

    // Drop game_on mid-window at dmg 3.
    ticks(2);
    @(negedge pclk) game_on = 1'b0;
    @(negedge pclk);
    chk("d_dmg", 32'(dmg0), 0);
    chk("d_inv", 32'(inv0), 0);
    chk("d_go",  32'(go0), 0);
    game_on = 1'b1;
    repeat (2) @(negedge pclk);
    hit0(2, mk(4'b0100, 1, 3'd1, 3'd2, 1, 0));
    ticks(60);
    hit0(1, mk(4'b0010, 1, 3'd2, 3'd1, 1, 0));
    ticks(60);
    hit0(0, mk(4'b0001, 1, 3'd3, 3'd0, 1, 0));
    ticks(60);
    hit0(3, mk(4'b1000, 1, 3'd4, 3'd3, 1, 0));
    ticks(60);
    hit0(2, mk(4'b0100, 1, 3'd5, 3'd2, 0, 1));
    chk("c_go", 32'(go0), 1);
    hit0(1, mk(4'b0010, 0, 3'd5, 3'd2, 0, 1));
    repeat (3) @(negedge pclk);
    chk("c_dmg_sat", 32'(dmg0), 5);

    // Asynchronous reset in the middle of a window.
    restart_game();
    hit0(0, mk(4'b0001, 1, 3'd1, 3'd0, 1, 0));
    ticks(3);
    @(posedge pclk);
    #2 rst = 1'b0;
    #1 chk_zero0("async");
    @(negedge pclk) rst = 1'b1;
    repeat (2) @(negedge pclk);
    hit0(1, mk(4'b0010, 1, 3'd1, 3'd1, 1, 0));

    // Zero-length window: all four held requests served 2 cycles apart.
    q1.push_back(mk(4'b0001, 1, 3'd1, 3'd0, 0, 0));
    q1.push_back(mk(4'b0010, 1, 3'd2, 3'd1, 0, 0));
    q1.push_back(mk(4'b0100, 1, 3'd3, 3'd2, 0, 0));
    q1.push_back(mk(4'b1000, 1, 3'd4, 3'd3, 0, 0));
    req1 = 4'b1111;
    for (int i = 0; i < 40 && req1 != 0; i++) @(negedge pclk);
    chk("u1_ack_timeout", 32'(req1), 0);

    repeat (5) @(negedge pclk);
    chk("u0_queue_left", q0.size(), 0);
    chk("u1_queue_left", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hit_scheduler.md
# hit_scheduler

Damage sequencer between the hazard/obstacle modules and the HP bar renderer. It arbitrates up to N_SRC hit requests round-robin and emits at most one single-cycle `player_hit` pulse per accepted hit. After each hit it enforces an invulnerability window counted in video frames, tracks accumulated damage, and raises `game_over` at the damage limit. `player_hit` drives the HP bar block's hit input; `invuln` feeds the player sprite for blinking.

## Interface
Parameters:
- `N_SRC`, 4: number of hit requesters (2..8).
- `MAX_DMG`, 5: hits until death (1..7).
- `IFRAME_FRAMES`, 60: invulnerability length in frames (0..255).

Ports:
- `pclk` in 1: pixel clock, the only clock.
- `rst` in 1: reset, asynchronous, active-low.
- `game_on` in 1: game running level.
- `vsync_in` in 1: vertical sync from the timing chain; a rising edge is one frame tick.
- `hit_req` in N_SRC: per-source level request, held until acked.
- `hit_ack` out N_SRC: one-hot single-cycle acknowledge.
- `player_hit` out 1: single-cycle damage pulse.
- `dmg_count` out 3: damage taken, 0..MAX_DMG.
- `invuln` out 1: high during the invulnerability window.
- `last_src` out 3: index of the most recently damaging source.
- `game_over` out 1: high in DEAD.

## Operation
- All outputs are registered. On reset, every output is 0. On reset, the state is IDLE, `rr_ptr` is 0, the frame counter is 0, and `vsync_prev` is 0.
- Frame tick: `tick = vsync_in & ~vsync_prev`. `vsync_prev` is registered every cycle.
- IDLE: `dmg_count`, `rr_ptr` and the frame counter are held at 0. No acks are issued. When `game_on` is high, go to ARMED.
- ARMED: if any `hit_req` bit is set, pick the winner round-robin.
  - Search starts at `rr_ptr` and wraps past N_SRC-1 to 0.
  - Next cycle: `player_hit`=1, `hit_ack[winner]`=1, `dmg_count`+1, `last_src`=winner, `rr_ptr`=(winner+1) mod N_SRC.
  - If the new `dmg_count` equals MAX_DMG, go to DEAD.
  - Otherwise, if IFRAME_FRAMES=0, stay in ARMED.
  - Otherwise go to INVULN with counter=IFRAME_FRAMES.
- INVULN: `invuln`=1.
  - Each tick decrements the counter. When the counter is 1 and a tick occurs, go to ARMED the next cycle.
  - Any asserted `hit_req` is absorbed: the lowest set index gets a one-cycle `hit_ack`. There is no `player_hit`, and `dmg_count` is unchanged.
  - `rr_ptr` does not advance on absorption.
- DEAD: `game_over`=1 and `invuln`=0. Requests are absorbed as in INVULN.
- `game_on` low in any state: next cycle go to IDLE. `dmg_count`, `game_over`, `invuln` and the counter are cleared. An in-flight ack or hit pulse is not issued.
- Simultaneous requests in ARMED: only the winner is acked that cycle. Losers stay pending and are absorbed in INVULN, so they cause no damage. If IFRAME_FRAMES=0, losers are served in later cycles.
- Width rules:
  - `winner` and `last_src` are 3 bits, zero-extended when N_SRC<8.
  - The counter is 8 bits.
  - `dmg_count` saturates at MAX_DMG; it never wraps.

## Timing
- Request-to-`player_hit`/`hit_ack` latency: 1 cycle (request sampled at edge k, pulse high during cycle k+1).
- Minimum spacing between `player_hit` pulses:
  - IFRAME_FRAMES>0: the full window plus 1 cycle.
  - IFRAME_FRAMES=0: 2 cycles. The ack must drop the request, and a still-high request is re-served only after its ack cycle; an acked source's `hit_req` is ignored in the ack cycle.
- `invuln` rises in the same cycle as `player_hit`.
- `invuln` falls 1 cycle after the IFRAME_FRAMES-th tick.
- `game_over` rises in the same cycle as the final `player_hit`.
- A tick arriving in the same cycle as entry to INVULN is not counted.
- Asynchronous reset mid-window: all outputs go to 0 immediately. On release, the block starts in IDLE.

## Test plan
- Reset, `game_on`=1, pulse `hit_req[2]` until acked -> `hit_ack`=4'b0100 and `player_hit`=1 one cycle later; `dmg_count`=1, `last_src`=2, `invuln`=1.
- `hit_req`=4'b1010 with `rr_ptr`=0 -> source 1 wins. Source 3 is absorbed during INVULN with no pulse. After 60 vsync edges `invuln`=0 and `dmg_count` is still 1.
- Five hits spaced beyond the window (MAX_DMG=5) -> `dmg_count`=5 and `game_over`=1 with the fifth pulse. A sixth request is absorbed and `dmg_count` stays 5.
- `game_on` dropped mid-INVULN (`dmg_count`=3) -> next cycle `dmg_count`=0, `invuln`=0, no pulses. Re-enable, then hit -> `dmg_count`=1.
- IFRAME_FRAMES=0 with `hit_req`=4'b1111 held until acked -> four pulses in source order 0,1,2,3, each 2 cycles apart.
- Assert `rst`=0 asynchronously mid-INVULN -> all outputs 0 before the next `pclk` edge; the block restarts from IDLE.
